// File: rtl/pkt_buffer_reader.sv
// Packet FIFO reader: parses a length header and streams the payload bytes little-endian.
// Optional statistics counters are built when PKT_BUFFER_READER_STATS_EN is defined.
module pkt_buffer_reader #(
    parameter int unsigned MAX_PKT_BYTES = 2048
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fifo_empty_i,
    output logic        fifo_rd_en_o,
    input  logic [63:0] fifo_data_i,
    output logic [7:0]  byte_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        err_o,
    output logic [31:0] pkt_count_o,
    output logic [15:0] drop_count_o
);

    localparam int unsigned WORD_W = 64;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WCNT_W = 14;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WCNT_W-1:0] words_left;
    logic [LEN_W-1:0]  bytes_left;
    logic              rd_inflight;
    logic [WORD_W-1:0] buf_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        buf_cnt;
    logic [2:0]        byte_idx;

    logic [LEN_W-1:0]  hdr_len;
    logic              hdr_ok;
    logic [WCNT_W-1:0] hdr_words;
    logic              rd_c;
    logic              word_rd_c;
    logic              err_c;
    logic              hs_c;
    logic              last_hs_c;
    logic              head_vld_c;
    logic [WORD_W-1:0] head_c;
    logic              load_c;
    logic              pop_c;

    assign hdr_len   = fifo_data_i[LEN_W-1:0];
    assign hdr_ok    = (hdr_len != '0) && (32'(hdr_len) <= 32'(MAX_PKT_BYTES));
    assign hdr_words = WCNT_W'((17'(hdr_len) + 17'd7) >> 3);

    // The word returning this cycle is usable straight off the bus when the buffer is empty.
    assign hs_c       = valid_o & ready_i;
    assign last_hs_c  = hs_c & last_o;
    assign head_vld_c = (buf_cnt != 2'd0) || rd_inflight;
    assign head_c     = (buf_cnt != 2'd0) ? buf_mem[rd_ptr] : fifo_data_i;
    assign load_c     = (state == S_DATA) && head_vld_c && (bytes_left != '0) && (!valid_o || ready_i);
    assign pop_c      = load_c && ((byte_idx == 3'd7) || (bytes_left == 16'd1));

    // Read enable stays combinational so it can never fire on a FIFO that just went empty.
    assign fifo_rd_en_o = rd_c & ~rst_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_c      = 1'b0;
        word_rd_c = 1'b0;
        err_c     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    rd_c      = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                if (hdr_ok) begin
                    state_nxt = S_DATA;
                end else begin
                    err_c     = 1'b1;
                    state_nxt = (hdr_len == '0) ? S_IDLE : S_DROP;
                end
            end
            S_DATA: begin
                if (last_hs_c) begin
                    if (!fifo_empty_i) begin
                        rd_c      = 1'b1;
                        state_nxt = S_HDR;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else if ((words_left != '0) && !fifo_empty_i &&
                             ((3'(buf_cnt) + 3'(rd_inflight)) < 3'd2)) begin
                    rd_c      = 1'b1;
                    word_rd_c = 1'b1;
                end
            end
            S_DROP: begin
                if (!fifo_empty_i) begin
                    rd_c      = 1'b1;
                    word_rd_c = 1'b1;
                    if (words_left == WCNT_W'(1)) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rd_inflight) buf_mem[wr_ptr] <= fifo_data_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            words_left  <= '0;
            bytes_left  <= '0;
            rd_inflight <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            buf_cnt     <= '0;
            byte_idx    <= '0;
            byte_o      <= '0;
            valid_o     <= 1'b0;
            last_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            err_o       <= err_c;
            rd_inflight <= word_rd_c && (state == S_DATA);

            if (state == S_HDR) begin
                words_left <= hdr_words;
                byte_idx   <= '0;
            end else if (word_rd_c) begin
                words_left <= words_left - WCNT_W'(1);
            end

            if (rd_inflight) wr_ptr <= ~wr_ptr;
            if (pop_c) begin
                rd_ptr   <= ~rd_ptr;
                byte_idx <= '0;
            end else if (load_c) begin
                byte_idx <= byte_idx + 3'd1;
            end
            buf_cnt <= buf_cnt + 2'(rd_inflight) - 2'(pop_c);

            if (state == S_HDR) begin
                bytes_left <= hdr_len;
            end else if (load_c) begin
                bytes_left <= bytes_left - 16'd1;
            end

            // Output register advances only when empty or being accepted, so a stall holds it.
            if (load_c) begin
                byte_o  <= head_c[{byte_idx, 3'b000} +: 8];
                valid_o <= 1'b1;
                last_o  <= (bytes_left == 16'd1);
            end else if (hs_c) begin
                valid_o <= 1'b0;
                last_o  <= 1'b0;
            end
        end
    end

`ifdef PKT_BUFFER_READER_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_count_o  <= '0;
            drop_count_o <= '0;
        end else begin
            if (last_hs_c) pkt_count_o  <= pkt_count_o + 32'd1;
            if (err_o)     drop_count_o <= drop_count_o + 16'd1;
        end
    end
`else
    assign pkt_count_o  = '0;
    assign drop_count_o = '0;
`endif

endmodule

// File: tb/tb_pkt_buffer_reader.sv
// Scoreboard bench for pkt_buffer_reader: FIFO model feeds packets, expected bytes are queued
// at push time and compared at every output handshake.
module tb_pkt_buffer_reader;

    localparam int unsigned MAXB = 2048;
`ifdef PKT_BUFFER_READER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fifo_empty_i = 1'b1;
    logic        fifo_rd_en_o;
    logic [63:0] fifo_data_i = '0;
    logic [7:0]  byte_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        last_o;
    logic        err_o;
    logic [31:0] pkt_count_o;
    logic [15:0] drop_count_o;

    always #5 clk = ~clk;

    pkt_buffer_reader #(.MAX_PKT_BYTES(MAXB)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .fifo_empty_i (fifo_empty_i),
        .fifo_rd_en_o (fifo_rd_en_o),
        .fifo_data_i  (fifo_data_i),
        .byte_o       (byte_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .last_o       (last_o),
        .err_o        (err_o),
        .pkt_count_o  (pkt_count_o),
        .drop_count_o (drop_count_o)
    );

    logic [63:0] fifo_q[$];
    logic [63:0] stage_q[$];
    logic [8:0]  exp_q[$];
    int          rd_cyc_q[$];
    int          rise_q[$];
    int          hs_cyc_q[$];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   rd_total = 0;
    int   err_total = 0;
    int   hs_total = 0;
    int   rd_empty_viol = 0;
    int   underflow_cnt = 0;
    int   stab_viol = 0;
    int   extra_hs = 0;
    int   pkt_exp = 0;
    int   drop_exp = 0;
    int   ready_mode = 0;
    bit   rd_req = 1'b0;
    bit   stall_prev = 1'b0;
    bit   prev_valid = 1'b0;
    logic [7:0] prev_byte = '0;
    logic       prev_last = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Standard FIFO model: pops on the edge after rd_en, data appears just after the edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (rd_req) begin
            if (fifo_q.size() == 0) underflow_cnt++;
            else fifo_data_i = fifo_q.pop_front();
        end
        fifo_empty_i = (fifo_q.size() == 0);
        case (ready_mode)
            0:       ready_i = 1'b1;
            1:       ready_i = ~ready_i;
            default: ready_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        rd_req = fifo_rd_en_o;
        if (rst_i) begin
            stall_prev = 1'b0;
        end else begin
            if (fifo_rd_en_o) begin
                rd_total++;
                rd_cyc_q.push_back(cyc);
                if (fifo_empty_i) rd_empty_viol++;
            end
            if (err_o) err_total++;
            if (valid_o && !prev_valid) rise_q.push_back(cyc);
            if (stall_prev && (!valid_o || byte_o !== prev_byte || last_o !== prev_last)) stab_viol++;
            if (valid_o && ready_i) begin
                hs_total++;
                hs_cyc_q.push_back(cyc);
                if (exp_q.size() == 0) extra_hs++;
                else chk("byte", 64'({last_o, byte_o}), 64'(exp_q.pop_front()));
            end
            stall_prev = valid_o && !ready_i;
        end
        prev_valid = valid_o;
        prev_byte  = byte_o;
        prev_last  = last_o;
    end

    task automatic push_pkt(input int len);
        logic [63:0] w;
        int nw;
        bit legal;
        nw    = (len + 7) / 8;
        legal = (len >= 1) && (len <= int'(MAXB));
        w = {$urandom, $urandom};
        w[15:0] = 16'(len);
        stage_q.push_back(w);
        for (int i = 0; i < nw; i++) begin
            w = {$urandom, $urandom};
            stage_q.push_back(w);
            if (legal)
                for (int k = 0; k < 8; k++)
                    if (i * 8 + k < len) exp_q.push_back({1'(i * 8 + k == len - 1), w[8 * k +: 8]});
        end
        if (legal) pkt_exp++;
        else drop_exp++;
    endtask

    task automatic release_all();
        while (stage_q.size() > 0) fifo_q.push_back(stage_q.pop_front());
    endtask

    task automatic release_n(input int n);
        for (int i = 0; i < n && stage_q.size() > 0; i++) fifo_q.push_back(stage_q.pop_front());
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || valid_o) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_pkt_cnt"}, 64'(pkt_count_o), STATS ? 64'(pkt_exp) : 64'd0);
        chk({tag, "_drop_cnt"}, 64'(drop_count_o), STATS ? 64'(drop_exp) : 64'd0);
    endtask

    initial begin
        int rd_base;
        int err_base;
        int n;

        // L=3 packet queued while reset is held; no read may start during reset.
        fifo_q.push_back(64'hFFFF_0000_1234_0003);
        fifo_q.push_back(64'h0000_0000_00CC_BBAA);
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b0, 8'hBB});
        exp_q.push_back({1'b1, 8'hCC});
        pkt_exp = 1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_last", 64'(last_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_byte", 64'(byte_o), 64'd0);
        chk("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
        chk("rst_pkt_cnt", 64'(pkt_count_o), 64'd0);
        chk("rst_drop_cnt", 64'(drop_count_o), 64'd0);
        rd_cyc_q.delete();
        rise_q.delete();
        rd_base = rd_total;
        @(posedge clk);
        #2 rst_i = 1'b0;
        wait_drain("l3");
        chk("l3_reads", 64'(rd_total - rd_base), 64'd2);
        chk("l3_rd_q", 64'(rd_cyc_q.size()), 64'd2);
        if (rd_cyc_q.size() >= 2 && rise_q.size() >= 1)
            chk("l3_latency", 64'(rise_q[0] - rd_cyc_q[1]), 64'd2);

        // L=16, back-to-back words: 16 consecutive handshakes.
        hs_cyc_q.delete();
        push_pkt(16);
        release_all();
        wait_drain("l16");
        chk("l16_count", 64'(hs_cyc_q.size()), 64'd16);
        if (hs_cyc_q.size() == 16) chk("l16_no_gap", 64'(hs_cyc_q[15] - hs_cyc_q[0]), 64'd15);

        // L=9 with ready toggling every cycle.
        ready_mode = 1;
        push_pkt(9);
        release_all();
        wait_drain("l9");
        ready_mode = 0;

        // Underrun mid-packet: only header + first word available for a while.
        push_pkt(16);
        release_n(2);
        repeat (30) @(negedge clk);
        chk("underrun_valid", 64'(valid_o), 64'd0);
        chk("underrun_pending", 64'(exp_q.size()), 64'd8);
        release_all();
        wait_drain("underrun");

        // L=0 header then L=2 packet.
        err_base = err_total;
        push_pkt(0);
        push_pkt(2);
        release_all();
        wait_drain("l0");
        chk("l0_err", 64'(err_total - err_base), 64'd1);
        chk_counters("l0");

        // Oversize header drained silently, then L=1.
        err_base = err_total;
        rd_base  = rd_total;
        push_pkt(int'(MAXB) + 1);
        push_pkt(1);
        release_all();
        wait_drain("big");
        chk("big_reads", 64'(rd_total - rd_base), 64'd260);
        chk("big_err", 64'(err_total - err_base), 64'd1);

        // Random lengths with random backpressure.
        ready_mode = 2;
        for (int p = 0; p < 6; p++) push_pkt(int'($urandom_range(1, 40)));
        release_all();
        wait_drain("rand");
        ready_mode = 0;
        chk_counters("rand");

        // Reset after 5 bytes of an L=20 packet.
        push_pkt(20);
        release_all();
        n = hs_total;
        rd_base = 0;
        while (hs_total - n < 5 && rd_base < 200) begin
            @(negedge clk);
            #1;
            rd_base++;
        end
        chk("mid_hs", 64'(hs_total - n), 64'd5);
        rst_i = 1'b1;
        fifo_q.delete();
        stage_q.delete();
        exp_q.delete();
        pkt_exp  = 0;
        drop_exp = 0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_valid", 64'(valid_o), 64'd0);
        @(posedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 64'(valid_o), 64'd0);
        chk("post_rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
        chk("post_rst_last", 64'(last_o), 64'd0);
        chk_counters("post_rst");
        push_pkt(4);
        release_all();
        wait_drain("l4");
        chk_counters("l4");

        chk("rd_while_empty", 64'(rd_empty_viol), 64'd0);
        chk("fifo_underflow", 64'(underflow_cnt), 64'd0);
        chk("stall_stable", 64'(stab_viol), 64'd0);
        chk("extra_bytes", 64'(extra_hs), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
